// File: rtl/demux14_rr_dispatcher_pkg.sv
// Shared definitions for the 1:4 demux dispatcher: channel count, select width,
// mode encodings, FSM state type and the one-hot helper.
package demux14_defs;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Turn a channel index into the matching one-hot channel-valid vector.
    function automatic logic [NCH-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux14_rr_dispatcher_rr_pick4.sv
// Round-robin candidate picker: first set mask bit scanning start, start+1,
// start+2, start+3 (indices wrap mod 4). Purely combinational.
module rr_pick4
    import demux14_defs::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    // Scan from start upward and take the first enabled channel.
    always_comb begin
        logic [SEL_W-1:0] cand;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = start + k[SEL_W-1:0];
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux14_rr_dispatcher.sv
// Dispatcher for a 1:4 demux: accepts words over valid/ready, holds one word,
// drives the select S and one-hot channel-valid Y, and counts completed
// transfers per channel with saturating counters.
module demux14_rr_dispatcher
    import demux14_defs::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   fix_sel,
    input  logic [NCH-1:0]     en_mask,
    input  logic               clr_cnt,
    output logic [W-1:0]       out_data,
    output logic [NCH-1:0]     Y,
    input  logic [NCH-1:0]     out_ready,
    output logic [SEL_W-1:0]   S,
    output logic [NCH*CW-1:0]  xfer_cnt
);

    state_t           state_q, state_d;
    logic [NCH-1:0]   y_q, y_d;
    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q [NCH];
    logic [CW-1:0]    cnt_d [NCH];

    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] tgt;
    logic             found;
    logic [SEL_W-1:0] cur;
    logic             accept;
    logic             complete;

    rr_pick4 u_pick (
        .mask  (en_mask),
        .start (s_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Index of the channel currently holding the word (0 when empty).
    always_comb begin
        cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (y_q[i]) cur = i[SEL_W-1:0];
        end
    end

    // Target selection for the next accepted word and the handshake terms.
    always_comb begin
        if (mode == MODE_FIXED) begin
            tgt   = fix_sel;
            found = en_mask[fix_sel];
        end else begin
            tgt   = rr_idx;
            found = rr_found;
        end
        complete = (state_q == ST_HOLD) && out_ready[cur];
        in_ready = !rst && found && ((state_q == ST_EMPTY) || out_ready[cur]);
        accept   = in_valid && in_ready;
    end

    // Next-state logic: a new accept always loads the hold register, even
    // when the previous word completes in the same cycle.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        data_d  = data_q;
        s_d     = (mode == MODE_FIXED) ? fix_sel : s_q;
        if (accept) begin
            state_d = ST_HOLD;
            y_d     = onehot4(tgt);
            data_d  = in_data;
            s_d     = (mode == MODE_FIXED) ? fix_sel : tgt + 2'd1;
        end else if (complete) begin
            state_d = ST_EMPTY;
            y_d     = '0;
        end
    end

    // Counter update: clear beats a coincident completion; increments saturate.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr_cnt) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (complete && (cnt_q[cur] != {CW{1'b1}})) begin
            cnt_d[cur] = cnt_q[cur] + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // State, hold and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            data_q  <= '0;
            s_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            data_q  <= data_d;
            s_q     <= s_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack the per-channel counters, channel n at [n*CW +: CW].
    always_comb begin
        xfer_cnt = '0;
        for (int n = 0; n < NCH; n++) begin
            xfer_cnt[n*CW +: CW] = cnt_q[n];
        end
    end

    assign out_data = data_q;
    assign Y        = y_q;
    assign S        = s_q;

endmodule

// File: doc/demux14_rr_dispatcher.md
Name: demux14_rr_dispatcher

Overview:
Dispatch controller that sequences a 1:4 demultiplexer. Accepts a word stream over a valid/ready handshake and routes each word to one of four output channels, driving the demux select S and one-hot channel-valid Y. Supports round-robin distribution over an enable mask, or a fixed channel. Keeps per-channel transfer counters. Sits between a single producer and four consumer lanes.

Parameters:
W, 8, data word width
CW, 8, width of each per-channel saturating transfer counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  W  word from producer
in_valid  input  1  producer has a word
in_ready  output  1  dispatcher accepts word this cycle
mode  input  1  0 = round-robin, 1 = fixed channel
fix_sel  input  2  target channel when mode=1
en_mask  input  4  channel enable, bit n = channel n
clr_cnt  input  1  synchronous clear of all counters
out_data  output  W  held word, shared by all channels
Y  output  4  one-hot channel valid (demux outputs)
out_ready  input  4  per-channel consumer ready
S  output  2  select pointer: next round-robin candidate, or fix_sel in fixed mode
xfer_cnt  output  4*CW  packed counters, channel n at [n*CW +: CW]

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values:
  - Y=0, out_data=0, S=0, all xfer_cnt=0, state=EMPTY.
  - in_ready is combinational and is 0 while rst is high.
  - rst asserted mid-operation discards the held word immediately, with no completion counted.
- States:
  - EMPTY (Y=0) and HOLD (Y one-hot).
  - EMPTY->HOLD on accept.
  - HOLD->EMPTY on completion without a new accept.
  - HOLD->HOLD on completion plus a simultaneous accept.
- Target pick (tgt, found):
  - RR mode: first set en_mask bit scanning S, S+1, S+2, S+3, indices mod 4.
  - Fixed mode: tgt=fix_sel, found=en_mask[fix_sel].
- in_ready = !rst && found && (state==EMPTY || out_ready[cur]), where cur is the index of the set Y bit.
- Accept = in_valid && in_ready. On accept:
  - out_data<=in_data, Y<=onehot(tgt).
  - RR mode: S<=(tgt+1) mod 4, wrapping 3->0.
  - Fixed mode: S<=fix_sel.
- S with no accept: RR mode holds S; fixed mode S follows fix_sel registered.
- Latency: 1 cycle from accept to Y/out_data valid. Throughput is 1 word per cycle when the consumer is always ready.
- Completion: Y[cur] && out_ready[cur]. out_ready bits for non-selected channels are ignored.
- Held word:
  - Never dropped or rerouted.
  - Changes to mode, fix_sel or en_mask (including clearing the cur bit) do not affect a word already in HOLD.
  - These changes apply only to the next pick.
- en_mask=0: found=0, so in_ready=0 and no accept. A word already held still completes normally.
- Counters:
  - On completion, xfer_cnt[cur]++.
  - Saturates at 2^CW-1, no wrap.
  - clr_cnt zeroes all counters next edge and wins over a coincident completion.
- in_data is ignored when no accept occurs. out_data is stable while in HOLD.

Decomposition:
- Shared package/header demux14_defs:
  - NCH=4, SEL_W=2
  - MODE_RR=1'b0, MODE_FIXED=1'b1
  - ST_EMPTY/ST_HOLD encodings
  - onehot4 function
- Sub-module rr_pick4: combinational, inputs mask[3:0] and start[1:0], outputs idx[1:0] and found. Unit-testable on its own.

Test Plan:
- Reset: rst=1 mid-HOLD with Y=4'b0100 -> Y=0, S=0, counters 0 without a clock edge; in_ready=0 while rst high.
- Round-robin, full mask: en_mask=4'hF, mode=0, out_ready=4'hF, in_valid=1, in_data=8'h10..8'h17 -> Y cycles 0001,0010,0100,1000,0001,…; one word per cycle; each xfer_cnt=2 after 8 words.
- Sparse mask skip: en_mask=4'b1010, start S=0 -> words go to ch1, ch3, ch1, ch3; S shows 2,0,2,0 after each accept; ch0/ch2 counts stay 0.
- Backpressure: out_ready=0 with word A=8'hAA in HOLD on ch2 -> in_ready=0, Y=0100, out_data=AA held 5 cycles; en_mask changed to 4'b0001 meanwhile; on out_ready[2]=1, A completes to ch2, next word goes to ch0.
- Fixed mode plus disabled channel: mode=1, fix_sel=3, en_mask=4'b0111 -> in_ready=0, no accept. Set en_mask=4'hF -> words go only to ch3, S=3.
- Counters: CW=2, 5 completions on ch0 -> xfer_cnt[0]=3 (saturated). clr_cnt coincident with a completion -> 0.
